// File: rtl/id_decode.sv
// Instruction-byte decoder with LDI/JMP/JZ multi-byte handling, branch flush and HALT.
// Optional feature macro: BRANCH_COND_EN enables the conditional JZ branch (opcode 101).
module id_decode (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] inst,
   input  logic [7:0] pc_calc,
   input  logic       zero_flag,
   output logic [7:0] pcj_mux,
   output logic       choice_mux,
   output logic       dec_valid,
   output logic [2:0] dec_op,
   output logic [1:0] dec_rd,
   output logic [1:0] dec_rs,
   output logic [7:0] dec_imm,
   output logic       halted
);

   typedef enum logic [2:0] {
      DECODE,
      WAIT_IMM,
      WAIT_TGT,
      FLUSH,
      HALT
   } state_t;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_SUB  = 3'b010;
   localparam logic [2:0] OP_LDI  = 3'b011;
   localparam logic [2:0] OP_JMP  = 3'b100;
   localparam logic [2:0] OP_JZ   = 3'b101;
   localparam logic [2:0] OP_AND  = 3'b110;
   localparam logic [2:0] OP_HALT = 3'b111;

   state_t     r_state;
   logic       r_taken;
   logic [1:0] r_ldiRd;
   logic [1:0] r_ldiRs;
   logic [7:0] r_pcjMux;
   logic       r_choiceMux;
   logic       r_decValid;
   logic [2:0] r_decOp;
   logic [1:0] r_decRd;
   logic [1:0] r_decRs;
   logic [7:0] r_decImm;
   logic       r_halted;

   logic [2:0] w_op;
   logic [1:0] w_rd;
   logic [1:0] w_rs;
   logic [7:0] w_haltTarget;

   assign w_op         = inst[7:5];
   assign w_rd         = inst[4:3];
   assign w_rs         = inst[2:1];
   // HALT re-points fetch at the HALT byte itself, wrapping 0x00 to 0xFF.
   assign w_haltTarget = pc_calc - 8'd1;

`ifndef BRANCH_COND_EN
   logic w_unusedZeroFlag;
   assign w_unusedZeroFlag = zero_flag;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= DECODE;
         r_taken     <= 1'b0;
         r_ldiRd     <= 2'd0;
         r_ldiRs     <= 2'd0;
         r_pcjMux    <= 8'h00;
         r_choiceMux <= 1'b0;
         r_decValid  <= 1'b0;
         r_decOp     <= 3'd0;
         r_decRd     <= 2'd0;
         r_decRs     <= 2'd0;
         r_decImm    <= 8'h00;
         r_halted    <= 1'b0;
      end else begin
         // Outputs are single-cycle pulses unless a state below re-asserts them.
         r_pcjMux    <= 8'h00;
         r_choiceMux <= 1'b0;
         r_decValid  <= 1'b0;
         r_decOp     <= 3'd0;
         r_decRd     <= 2'd0;
         r_decRs     <= 2'd0;
         r_decImm    <= 8'h00;
         case (r_state)
            DECODE: begin
               case (w_op)
                  OP_NOP: begin
                     r_decValid <= 1'b1;
                  end
                  OP_ADD, OP_SUB, OP_AND: begin
                     r_decValid <= 1'b1;
                     r_decOp    <= w_op;
                     r_decRd    <= w_rd;
                     r_decRs    <= w_rs;
                  end
                  OP_LDI: begin
                     r_ldiRd <= w_rd;
                     r_ldiRs <= w_rs;
                     r_state <= WAIT_IMM;
                  end
                  OP_JMP: begin
                     r_taken <= 1'b1;
                     r_state <= WAIT_TGT;
                  end
                  OP_JZ: begin
`ifdef BRANCH_COND_EN
                     r_taken <= zero_flag;
                     r_state <= WAIT_TGT;
`else
                     r_decValid <= 1'b1;
`endif
                  end
                  OP_HALT: begin
                     r_halted    <= 1'b1;
                     r_choiceMux <= 1'b1;
                     r_pcjMux    <= w_haltTarget;
                     r_state     <= HALT;
                  end
                  default: r_state <= DECODE;
               endcase
            end
            WAIT_IMM: begin
               r_decValid <= 1'b1;
               r_decOp    <= OP_LDI;
               r_decRd    <= r_ldiRd;
               r_decRs    <= r_ldiRs;
               r_decImm   <= inst;
               r_state    <= DECODE;
            end
            WAIT_TGT: begin
               r_taken <= 1'b0;
               if (r_taken) begin
                  r_pcjMux    <= inst;
                  r_choiceMux <= 1'b1;
                  r_state     <= FLUSH;
               end else begin
                  r_state <= DECODE;
               end
            end
            FLUSH: begin
               r_state <= DECODE;
            end
            HALT: begin
               r_halted    <= 1'b1;
               r_choiceMux <= 1'b1;
               r_pcjMux    <= r_pcjMux;
            end
            default: r_state <= DECODE;
         endcase
      end
   end

   assign pcj_mux    = r_pcjMux;
   assign choice_mux = r_choiceMux;
   assign dec_valid  = r_decValid;
   assign dec_op     = r_decOp;
   assign dec_rd     = r_decRd;
   assign dec_rs     = r_decRs;
   assign dec_imm    = r_decImm;
   assign halted     = r_halted;

endmodule

// File: tb/tb_id_decode.sv
// Self-checking bench for id_decode: directed scenarios then random byte streams
// compared against a byte-role reference model (honours BRANCH_COND_EN).
module tb_id_decode;

   logic       clock;
   logic       reset;
   logic [7:0] inst;
   logic [7:0] pc_calc;
   logic       zero_flag;
   logic [7:0] pcj_mux;
   logic       choice_mux;
   logic       dec_valid;
   logic [2:0] dec_op;
   logic [1:0] dec_rd;
   logic [1:0] dec_rs;
   logic [7:0] dec_imm;
   logic       halted;

   int checkCount;
   int errorCount;

   // Reference model: what role the next byte plays, plus expected outputs.
   bit       mHalted, mNeedImm, mNeedTgt, mSkip, mTaken, mLastReset;
   int       mRd, mRs, mHaltPc;
   int       eValid, eOp, eRd, eRs, eImm, eChoice, ePcj, eHalted;

   id_decode dut (
      .clock      (clock),
      .reset      (reset),
      .inst       (inst),
      .pc_calc    (pc_calc),
      .zero_flag  (zero_flag),
      .pcj_mux    (pcj_mux),
      .choice_mux (choice_mux),
      .dec_valid  (dec_valid),
      .dec_op     (dec_op),
      .dec_rd     (dec_rd),
      .dec_rs     (dec_rs),
      .dec_imm    (dec_imm),
      .halted     (halted)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed != expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Advance the model by one byte, given the inputs the DUT sampled this edge.
   task automatic modelStep(input bit rst, input int b, input int pc, input bit zf);
      int op;
      op = b / 32;
      eValid = 0; eOp = 0; eRd = 0; eRs = 0; eImm = 0;
      eChoice = 0; ePcj = 0; eHalted = 0;
      mLastReset = rst;
      if (rst) begin
         mHalted = 0; mNeedImm = 0; mNeedTgt = 0; mSkip = 0; mTaken = 0;
      end else if (mHalted) begin
         eHalted = 1; eChoice = 1; ePcj = mHaltPc;
      end else if (mSkip) begin
         mSkip = 0;
      end else if (mNeedImm) begin
         mNeedImm = 0;
         eValid = 1; eOp = 3; eRd = mRd; eRs = mRs; eImm = b;
      end else if (mNeedTgt) begin
         mNeedTgt = 0;
         if (mTaken) begin
            eChoice = 1; ePcj = b; mSkip = 1;
         end
      end else begin
         if (op == 1 || op == 2 || op == 6) begin
            eValid = 1; eOp = op; eRd = (b / 8) % 4; eRs = (b / 2) % 4;
         end else if (op == 0) begin
            eValid = 1;
         end else if (op == 3) begin
            mNeedImm = 1; mRd = (b / 8) % 4; mRs = (b / 2) % 4;
         end else if (op == 4) begin
            mNeedTgt = 1; mTaken = 1;
         end else if (op == 5) begin
`ifdef BRANCH_COND_EN
            mNeedTgt = 1; mTaken = zf;
`else
            eValid = 1;
`endif
         end else begin
            mHalted = 1;
            mHaltPc = (pc + 255) % 256;
            eHalted = 1; eChoice = 1; ePcj = mHaltPc;
         end
      end
   endtask

   task automatic compareModel();
      checkOutput("dec_valid", dec_valid, eValid);
      checkOutput("choice_mux", choice_mux, eChoice);
      checkOutput("halted", halted, eHalted);
      if (eValid != 0) begin
         checkOutput("dec_op", dec_op, eOp);
         checkOutput("dec_rd", dec_rd, eRd);
         checkOutput("dec_rs", dec_rs, eRs);
         checkOutput("dec_imm", dec_imm, eImm);
      end
      if (eChoice != 0) checkOutput("pcj_mux", pcj_mux, ePcj);
      if (mLastReset) begin
         checkOutput("rst_pcj", pcj_mux, 0);
         checkOutput("rst_op", dec_op, 0);
         checkOutput("rst_rd", dec_rd, 0);
         checkOutput("rst_rs", dec_rs, 0);
         checkOutput("rst_imm", dec_imm, 0);
      end
   endtask

   // Present one byte, let the DUT sample it, then check the registered result.
   task automatic applyStimulus(input bit rst, input logic [7:0] b, input logic [7:0] pc, input bit zf);
      reset     = rst;
      inst      = b;
      pc_calc   = pc;
      zero_flag = zf;
      @(posedge clock);
      #1;
      modelStep(rst, b, pc, zf);
      compareModel();
   endtask

   initial begin
      logic [7:0] rb;
      bit         rr;
      checkCount = 0;
      errorCount = 0;
      reset = 1'b1; inst = 8'h00; pc_calc = 8'h00; zero_flag = 1'b0;

      applyStimulus(1, 8'h00, 8'h00, 0);
      applyStimulus(1, 8'hE0, 8'h00, 1);
      checkOutput("reset_valid", dec_valid, 0);
      checkOutput("reset_halted", halted, 0);

      applyStimulus(0, 8'h2A, 8'h01, 0);
      checkOutput("add_op", dec_op, 1);
      checkOutput("add_rd", dec_rd, 1);
      checkOutput("add_rs", dec_rs, 1);

      applyStimulus(0, 8'h60, 8'h02, 0);
      checkOutput("ldi_first_valid", dec_valid, 0);
      applyStimulus(0, 8'h5C, 8'h03, 0);
      checkOutput("ldi_imm", dec_imm, 8'h5C);
      checkOutput("ldi_op", dec_op, 3);

      applyStimulus(0, 8'h80, 8'h04, 0);
      applyStimulus(0, 8'h1C, 8'h05, 0);
      checkOutput("jmp_pcj", pcj_mux, 8'h1C);
      checkOutput("jmp_choice", choice_mux, 1);
      applyStimulus(0, 8'h2A, 8'h1D, 0);
      checkOutput("jmp_flush_valid", dec_valid, 0);
      checkOutput("jmp_flush_choice", choice_mux, 0);

      applyStimulus(0, 8'hA0, 8'h1D, 0);
      applyStimulus(0, 8'h0C, 8'h1E, 1);
      checkOutput("jz_nt_choice", choice_mux, 0);
      applyStimulus(0, 8'h2A, 8'h1F, 1);
      checkOutput("jz_nt_next_add", dec_op, 1);
      applyStimulus(0, 8'hA0, 8'h20, 1);
`ifdef BRANCH_COND_EN
      applyStimulus(0, 8'h0C, 8'h21, 0);
      checkOutput("jz_t_pcj", pcj_mux, 8'h0C);
      checkOutput("jz_t_choice", choice_mux, 1);
`else
      checkOutput("jz_as_nop_valid", dec_valid, 1);
      applyStimulus(0, 8'h0C, 8'h21, 0);
      checkOutput("jz_off_choice", choice_mux, 0);
`endif
      applyStimulus(0, 8'h00, 8'h22, 0);

      applyStimulus(0, 8'h80, 8'h30, 0);
      applyStimulus(1, 8'h1C, 8'h31, 0);
      checkOutput("abort_choice", choice_mux, 0);
      applyStimulus(0, 8'h2A, 8'h00, 0);
      checkOutput("abort_then_add", dec_op, 1);
      checkOutput("abort_then_valid", dec_valid, 1);

      applyStimulus(0, 8'hE0, 8'h10, 0);
      checkOutput("halt_pcj", pcj_mux, 8'h0F);
      applyStimulus(0, 8'h2A, 8'h55, 0);
      checkOutput("halt_hold_pcj", pcj_mux, 8'h0F);
      checkOutput("halt_hold_halted", halted, 1);
      applyStimulus(1, 8'h00, 8'h00, 0);
      checkOutput("halt_reset_halted", halted, 0);
      applyStimulus(0, 8'hE0, 8'h00, 0);
      checkOutput("halt_wrap_pcj", pcj_mux, 8'hFF);
      applyStimulus(1, 8'h00, 8'h00, 0);

      for (int i = 0; i < 3000; i++) begin
         rb = 8'($urandom);
         if (rb[7:5] == 3'b111 && $urandom_range(0, 3) != 0) rb[7:5] = 3'b001;
         rr = ($urandom_range(0, 29) == 0);
         applyStimulus(rr, rb, 8'($urandom), 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/id_decode.md
ID_DECODE -- requirements
Module: id_decode

Interface
REQ-001 clock  input  1  single system clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset; sampled on rising edge of clock.
REQ-003 inst  input  8  instruction byte presented by the fetch stage this cycle.
REQ-004 pc_calc  input  8  fetch-stage PC+1 matching inst (address of the next sequential byte).
REQ-005 zero_flag  input  1  execute-stage zero flag, used by JZ.
REQ-006 pcj_mux  output  8  jump target driven to the fetch-stage PC mux.
REQ-007 choice_mux  output  1  PC mux select; 1 = load pcj_mux, 0 = sequential.
REQ-008 dec_valid  output  1  dec_* fields hold a valid decoded instruction this cycle.
REQ-009 dec_op  output  3  decoded opcode.
REQ-010 dec_rd, dec_rs  output  2 each  destination and source register indices.
REQ-011 dec_imm  output  8  immediate byte (LDI only, else 0).
REQ-012 halted  output  1  decoder has executed HALT.

Function
REQ-013 Encoding SHALL be: op = inst[7:5], rd = inst[4:3], rs = inst[2:1]; 000 NOP, 001 ADD, 010 SUB, 011 LDI (2-byte), 100 JMP (2-byte), 101 JZ (2-byte), 110 AND, 111 HALT.
REQ-014 All outputs SHALL be registered; decode latency SHALL be one cycle from inst sample to dec_valid.
REQ-015 FSM states SHALL be DECODE, WAIT_IMM, WAIT_TGT, FLUSH, HALT.
REQ-016 DECODE: 1-byte ops (NOP/ADD/SUB/AND) SHALL assert dec_valid for one cycle with fields; NOP asserts dec_valid with rd=rs=0.
REQ-017 DECODE + LDI SHALL go to WAIT_IMM with dec_valid=0; the next byte SHALL be taken as dec_imm and dec_valid asserted with op=011, then return to DECODE.
REQ-018 DECODE + JMP SHALL go to WAIT_TGT latching "taken"; DECODE + JZ SHALL latch taken = zero_flag sampled in the opcode cycle.
REQ-019 WAIT_TGT: next byte is the target; if taken, pcj_mux = target and choice_mux = 1 for exactly one cycle, state -> FLUSH; if not taken, choice_mux = 0, state -> DECODE.
REQ-020 FLUSH SHALL discard the byte present (sequential byte fetched before redirect), dec_valid = 0, then -> DECODE.
REQ-021 JMP/JZ SHALL never assert dec_valid; the target byte SHALL never be decoded as an opcode.
REQ-022 HALT SHALL assert halted, drive pcj_mux = pc_calc - 1 (mod 256) and choice_mux = 1 continuously, dec_valid = 0, and remain in HALT until reset.
REQ-023 Address arithmetic SHALL be 8-bit modulo 256 (pc_calc = 0x00 on HALT gives pcj_mux = 0xFF).
REQ-024 choice_mux SHALL be 0 in every state except the cycle after a taken WAIT_TGT and HALT.

Reset
REQ-025 Reset SHALL force state DECODE, taken = 0, and all outputs to 0 (pcj_mux 0x00, choice_mux 0, dec_valid 0, dec_op/rd/rs 0, dec_imm 0x00, halted 0).
REQ-026 Reset asserted in any state (including mid 2-byte instruction, FLUSH or HALT) SHALL abort the operation with no partial output on the following cycle.

Configuration
REQ-027 Macro BRANCH_COND_EN: when defined, JZ SHALL behave per REQ-018/019.
REQ-028 When BRANCH_COND_EN is undefined, opcode 101 SHALL decode as a 1-byte NOP (dec_valid=1, dec_op=000), zero_flag SHALL be ignored, and choice_mux SHALL never assert for opcode 101.

Verification
REQ-029 Reset then inst = 0x2A (ADD rd=1, rs=1) -> next cycle dec_valid=1, dec_op=001, dec_rd=1, dec_rs=1, choice_mux=0.
REQ-030 inst 0x60 then 0x5C (LDI 0x5C) -> dec_valid low first cycle, then dec_valid=1, dec_op=011, dec_imm=0x5C.
REQ-031 inst 0x80 then 0x1C (JMP 0x1C) -> pcj_mux=0x1C, choice_mux=1 one cycle; next byte (e.g. 0x2A) discarded, dec_valid=0.
REQ-032 JZ 0xA0 with zero_flag=0, target 0x0C -> choice_mux stays 0, next byte decoded normally; repeat with zero_flag=1 -> choice_mux=1, pcj_mux=0x0C (BRANCH_COND_EN defined); undefined -> 0xA0 decodes as NOP.
REQ-033 inst 0xE0 with pc_calc=0x10 -> halted=1, pcj_mux=0x0F, choice_mux=1 held; reset asserted -> all outputs 0 next cycle.
REQ-034 Reset asserted during WAIT_TGT after 0x80 -> no redirect, state DECODE, following 0x2A decoded as ADD.
